mam_wb_master: RTL and testbench
================================

# mam_wb_master

Parametrised MAM-to-Wishbone bus master. Sits between the MAM request/data streams and a Wishbone B3 bus. Generalises the single-beat/burst interface with:
- configurable data width and byte lanes,
- splitting of long MAM bursts into Wishbone incrementing bursts of at most MAX_BURST beats,
- read backpressure through a one-entry buffer,
- ERR_I termination with an error/done report.

## Interface
- DATA_WIDTH, 16: data bus width; multiple of 8, ≥8.
- ADDR_WIDTH, 32: byte address width.
- MAX_BURST, 8: maximum beats per Wishbone cycle; ≥1, ≤16383.
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when both high.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  start byte address, aligned to DATA_WIDTH/8.
- req_burst  in  1  1 = burst of req_beats beats, 0 = single beat.
- req_beats  in  14  beat count; 0 with req_burst=1 is treated as 1.
- write_valid / write_ready  in / out  1  write beat handshake.
- write_data  in  DATA_WIDTH  write beat data.
- write_strb  in  DATA_WIDTH/8  byte enables.
- read_valid / read_ready  out / in  1  read beat handshake.
- read_data  out  DATA_WIDTH  read beat data.
- done  out  1  one-cycle pulse when a request completes.
- done_err  out  1  valid with done; 1 if any beat saw ERR_I.
- CYC_O, STB_O, WE_O  out  1  Wishbone cycle, strobe, write enable.
- ADDR_O  out  ADDR_WIDTH  Wishbone byte address.
- DAT_O  out  DATA_WIDTH  Wishbone write data.
- SEL_O  out  DATA_WIDTH/8  byte selects.
- CTI_O  out  3  cycle type.
- BTE_O  out  2  burst type; constant 2'b00 (linear).
- DAT_I  in  DATA_WIDTH  Wishbone read data.
- ACK_I, ERR_I  in  1  Wishbone terminations.

## Operation
- **States:** IDLE, BUS, GAP, DRAIN, RESP.
- **IDLE:** req_ready=1. On accept:
  - latch rw, addr, and total = (req_burst ? max(req_beats,1) : 1); clear err flag.
  - seg = min(total, MAX_BURST).
  - Go to BUS.
- **BUS:** CYC_O=1.
  - Write: STB_O = write beat buffer valid. WE_O=1, DAT_O/SEL_O from the buffer.
  - Read: STB_O = read buffer empty or read_ready. SEL_O = all ones.
  - A beat completes on a clock edge with STB_O&&(ACK_I||ERR_I). Then ADDR_O += DATA_WIDTH/8, total−1, seg−1.
- **CTI_O:**
  - Single request: 3'b000.
  - Burst request: 3'b010 on all but the last beat of a segment, 3'b111 on the segment's last beat.
- **Segment end:**
  - seg reaches 0 with total>0: go to GAP. GAP holds CYC_O=0 for one cycle, reloads seg = min(total, MAX_BURST), then returns to BUS.
  - total reaches 0: go to RESP.
- **ERR_I on a completing beat:**
  - Set err; drop CYC_O next cycle.
  - Write with beats remaining: go to DRAIN. write_ready=1, remaining beats are consumed and discarded. When count reaches 0, go to RESP.
  - Read with beats remaining: DRAIN returns remaining beats as read_data=0 through the read buffer, then goes to RESP.
  - The error beat's own read data is passed with value 0.
- **RESP:** done=1, done_err=err for one cycle, then IDLE.
- **Write buffer:** one entry.
  - write_ready = (BUS or DRAIN) && (buffer empty || beat completing) && beats not yet loaded > 0.
  - The block never accepts more write beats than requested.
- **Read buffer:** one entry.
  - DAT_I captured on ACK_I.
  - read_valid held until read_ready; read_data stable while read_valid && !read_ready.
- RESP is entered only after the read buffer is drained.

## Timing
- Reset: every output 0 while RST_I is sampled high, including req_ready, CYC_O, STB_O, read_valid, write_ready, done. State goes to IDLE and buffers are cleared.
- RST_I mid-transfer: CYC_O is 0 the cycle after; pending data is discarded and no done pulse is issued.
- Request accept to CYC_O=1: 1 cycle.
- Read: read_valid asserts the cycle after the ACK_I edge.
- Throughput: one beat per cycle when ACK_I is held high and the streams are not throttled.
- Last beat ACK to done: 1 cycle for writes; for reads, the cycle after the final read handshake.
- ACK_I and ERR_I both high: treat as ERR_I.
- ACK_I/ERR_I while STB_O=0: ignored.

## Structure
- Package mam_wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111, BTE_LINEAR=2'b00,
  - the state enum.
- Sub-module mam_wb_beat_buf: a one-entry valid/ready buffer parametrised by width. It is instantiated twice: write path {data, strb}, read path data.

## Test plan
- Single write, addr 0x100, data 0x000F, strb 2'b11 -> one beat: ADDR_O=0x100, CTI_O=000, SEL_O=11; done=1, done_err=0.
- Burst write of 6 beats, data 0x0001..0x0006, MAX_BURST=4 -> two cycles of 4+2 beats:
  - ADDR_O 0x0,0x2..0xA;
  - CTI_O 010,010,010,111 | 010,111;
  - CYC_O low for exactly 1 cycle between the two cycles.
- Burst read of 4 beats with read_ready toggled every other cycle -> data 0x0001..0x0004 delivered in order with none lost; STB_O low while the buffer is full.
- ERR_I on write beat 2 of 5 -> CYC_O drops; 3 remaining write beats are accepted and discarded; done_err=1.
- ERR_I on read beat 3 of 4 -> beats 3 and 4 are read as 0; done_err=1.
- RST_I asserted mid-burst -> CYC_O=0 next cycle; no done pulse; a new single read completes normally.

Source files
------------

// File: rtl/mam_wb_pkg.sv
// Shared constants, state encoding and helpers for the MAM-to-Wishbone master.
package mam_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   localparam int unsigned BEATS_W = 14;

   typedef enum logic [2:0] {
      IDLE,
      BUS,
      GAP,
      DRAIN,
      RESP
   } state_t;

   // Beats in the next Wishbone cycle: the remainder, capped at the burst limit.
   function automatic logic [BEATS_W-1:0] seg_len(input logic [BEATS_W-1:0] total,
                                                  input logic [BEATS_W-1:0] max_burst);
      return (total < max_burst) ? total : max_burst;
   endfunction

endpackage

// File: rtl/mam_wb_beat_buf.sv
// One-entry valid/ready buffer; accepts a new beat in the same cycle the held one leaves.
module mam_wb_beat_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;

   assign in_ready  = !full_q || out_ready;
   assign out_valid = full_q;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (in_valid && in_ready) begin
         full_q <= 1'b1;
         data_q <= in_data;
      end else if (out_ready) begin
         full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mam_wb_master.sv
// MAM request/data streams to Wishbone B3 master with burst splitting,
// read backpressure and error draining.
module mam_wb_master
   import mam_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_burst,
   input  logic [BEATS_W-1:0]      req_beats,
   input  logic                    write_valid,
   output logic                    write_ready,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strb,
   output logic                    read_valid,
   input  logic                    read_ready,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    done,
   output logic                    done_err,
   output logic                    CYC_O,
   output logic                    STB_O,
   output logic                    WE_O,
   output logic [ADDR_WIDTH-1:0]   ADDR_O,
   output logic [DATA_WIDTH-1:0]   DAT_O,
   output logic [DATA_WIDTH/8-1:0] SEL_O,
   output logic [2:0]              CTI_O,
   output logic [1:0]              BTE_O,
   input  logic [DATA_WIDTH-1:0]   DAT_I,
   input  logic                    ACK_I,
   input  logic                    ERR_I
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned WBUF_W = DATA_WIDTH + STRB_W;
   localparam logic [BEATS_W-1:0] MAX_SEG = BEATS_W'(MAX_BURST);
   localparam logic [BEATS_W-1:0] ONE     = BEATS_W'(1);

   state_t                  state_q, state_d;
   logic                    rw_q, rw_d, burst_q, burst_d, err_q, err_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BEATS_W-1:0]      total_q, total_d, seg_q, seg_d, to_load_q, to_load_d;
   logic [BEATS_W-1:0]      req_total;

   logic                    in_bus, in_drain, stb, beat_done, load_en, wr_fire;
   logic                    wbuf_in_ready, wbuf_valid, wbuf_out_ready;
   logic [WBUF_W-1:0]       wbuf_out;
   logic                    rbuf_in_valid, rbuf_in_ready, rbuf_valid;
   logic [DATA_WIDTH-1:0]   rbuf_in_data, rbuf_data;

   assign in_bus    = (state_q == BUS);
   assign in_drain  = (state_q == DRAIN);
   assign stb       = in_bus && (rw_q ? wbuf_valid : rbuf_in_ready);
   assign beat_done = stb && (ACK_I || ERR_I);
   assign load_en   = (in_bus || in_drain) && rw_q && (to_load_q != '0);
   assign wr_fire   = load_en && wbuf_in_ready && write_valid;
   assign req_total = (!req_burst || req_beats == '0) ? ONE : req_beats;

   // During a write drain the buffer is emptied every cycle, discarding its beat.
   assign wbuf_out_ready = (in_bus && beat_done) || (in_drain && rw_q);
   assign rbuf_in_valid  = !rw_q && ((in_bus && beat_done) || (in_drain && total_q != '0));
   assign rbuf_in_data   = (in_bus && !ERR_I) ? DAT_I : '0;

   mam_wb_beat_buf #(.WIDTH(WBUF_W)) u_wbuf (
      .clk       (CLK_I),
      .rst       (RST_I),
      .in_valid  (write_valid && load_en),
      .in_ready  (wbuf_in_ready),
      .in_data   ({write_data, write_strb}),
      .out_valid (wbuf_valid),
      .out_ready (wbuf_out_ready),
      .out_data  (wbuf_out)
   );

   mam_wb_beat_buf #(.WIDTH(DATA_WIDTH)) u_rbuf (
      .clk       (CLK_I),
      .rst       (RST_I),
      .in_valid  (rbuf_in_valid),
      .in_ready  (rbuf_in_ready),
      .in_data   (rbuf_in_data),
      .out_valid (rbuf_valid),
      .out_ready (read_ready),
      .out_data  (rbuf_data)
   );

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q   <= IDLE;
         rw_q      <= 1'b0;
         burst_q   <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         total_q   <= '0;
         seg_q     <= '0;
         to_load_q <= '0;
      end else begin
         state_q   <= state_d;
         rw_q      <= rw_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         total_q   <= total_d;
         seg_q     <= seg_d;
         to_load_q <= to_load_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rw_d      = rw_q;
      burst_d   = burst_q;
      err_d     = err_q;
      addr_d    = addr_q;
      total_d   = total_q;
      seg_d     = seg_q;
      to_load_d = wr_fire ? (to_load_q - ONE) : to_load_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rw_d      = req_rw;
               burst_d   = req_burst;
               addr_d    = req_addr;
               err_d     = 1'b0;
               total_d   = req_total;
               seg_d     = seg_len(req_total, MAX_SEG);
               to_load_d = req_rw ? req_total : '0;
               state_d   = BUS;
            end
         end
         BUS: begin
            if (beat_done) begin
               addr_d  = addr_q + ADDR_WIDTH'(STRB_W);
               total_d = total_q - ONE;
               seg_d   = seg_q - ONE;
               if (ERR_I) err_d = 1'b1;
               // Reads finish in DRAIN so the last beat leaves the buffer before done.
               if (total_q == ONE)    state_d = rw_q ? RESP : DRAIN;
               else if (ERR_I)        state_d = DRAIN;
               else if (seg_q == ONE) state_d = GAP;
            end
         end
         GAP: begin
            seg_d   = seg_len(total_q, MAX_SEG);
            state_d = BUS;
         end
         DRAIN: begin
            if (rw_q) begin
               if (wbuf_valid) begin
                  total_d = total_q - ONE;
                  if (total_q == ONE) state_d = RESP;
               end
            end else begin
               if (rbuf_in_valid && rbuf_in_ready) total_d = total_q - ONE;
               if (total_q == '0 && (!rbuf_valid || read_ready)) state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low while reset is sampled high.
   assign req_ready   = !RST_I && (state_q == IDLE);
   assign write_ready = !RST_I && load_en && wbuf_in_ready;
   assign read_valid  = !RST_I && rbuf_valid;
   assign read_data   = RST_I ? '0 : rbuf_data;
   assign done        = !RST_I && (state_q == RESP);
   assign done_err    = done && err_q;
   assign CYC_O       = !RST_I && in_bus;
   assign STB_O       = !RST_I && stb;
   assign WE_O        = CYC_O && rw_q;
   assign ADDR_O      = RST_I ? '0 : addr_q;
   assign DAT_O       = WE_O ? wbuf_out[WBUF_W-1:STRB_W] : '0;
   assign SEL_O       = !CYC_O ? '0 : (rw_q ? wbuf_out[STRB_W-1:0] : '1);
   assign CTI_O       = (!CYC_O || !burst_q) ? CTI_CLASSIC :
                        ((seg_q == ONE) ? CTI_END : CTI_INCR);
   assign BTE_O       = BTE_LINEAR;

endmodule

// File: tb/tb_mam_wb_master.sv
// Directed bench for mam_wb_master: single/burst writes, throttled reads, errors, reset.
module tb_mam_wb_master;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        req_valid, req_ready, req_rw, req_burst;
   logic [31:0] req_addr;
   logic [13:0] req_beats;
   logic        write_valid, write_ready;
   logic [15:0] write_data;
   logic [1:0]  write_strb;
   logic        read_valid, read_ready;
   logic [15:0] read_data;
   logic        done, done_err;
   logic        CYC_O, STB_O, WE_O;
   logic [31:0] ADDR_O;
   logic [15:0] DAT_O, DAT_I;
   logic [1:0]  SEL_O, BTE_O;
   logic [2:0]  CTI_O;
   logic        ACK_I, ERR_I;

   mam_wb_master #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
      .write_valid(write_valid), .write_ready(write_ready),
      .write_data(write_data), .write_strb(write_strb),
      .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
      .done(done), .done_err(done_err),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADDR_O(ADDR_O),
      .DAT_O(DAT_O), .SEL_O(SEL_O), .CTI_O(CTI_O), .BTE_O(BTE_O),
      .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
   );

   always #5 CLK_I = ~CLK_I;

   int n_chk = 0;
   int n_fail = 0;

   // Slave: always acknowledges; read data is word index + 1; optional error at one address.
   logic        err_on;
   logic [31:0] err_addr;
   assign ACK_I = STB_O;
   assign ERR_I = err_on && STB_O && (ADDR_O == err_addr);
   assign DAT_I = ADDR_O[16:1] + 16'd1;

   // Write source: wr_lim beats counting up from wr_base.
   int          wr_acc = 0;
   int          wr_start = 0;
   int          wr_lim;
   logic [15:0] wr_base;
   assign write_valid = (wr_acc - wr_start) < wr_lim;
   assign write_data  = wr_base + 16'(wr_acc - wr_start);
   assign write_strb  = 2'b11;

   logic rr_tog;
   logic rr_ph = 1'b0;
   assign read_ready = rr_tog ? rr_ph : 1'b1;

   logic [31:0] log_addr[$];
   logic [2:0]  log_cti[$];
   logic [15:0] log_dat[$];
   logic [1:0]  log_sel[$];
   logic [15:0] rd_q[$];
   bit          cyc_h[$];
   int          done_cnt = 0;
   int          stb_viol = 0;
   logic        last_err = 1'b0;

   always @(posedge CLK_I) begin
      if (STB_O && (ACK_I || ERR_I)) begin
         log_addr.push_back(ADDR_O);
         log_cti.push_back(CTI_O);
         log_dat.push_back(DAT_O);
         log_sel.push_back(SEL_O);
      end
      if (read_valid && read_ready) rd_q.push_back(read_data);
      if (write_valid && write_ready) wr_acc <= wr_acc + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         last_err <= done_err;
      end
      if (read_valid && !read_ready && STB_O) stb_viol <= stb_viol + 1;
      cyc_h.push_back(CYC_O);
      rr_ph <= ~rr_ph;
   end

   task automatic issue(input logic rw, input logic [31:0] a, input logic b, input logic [13:0] n);
      int k = 0;
      req_valid = 1'b1; req_rw = rw; req_addr = a; req_burst = b; req_beats = n;
      @(negedge CLK_I);
      while (!req_ready && k < 50) begin
         @(negedge CLK_I);
         k++;
      end
      n_chk++;
      if (!req_ready) begin
         n_fail++;
         $display("FAIL req_accept: req_ready=%0b required 1", req_ready);
      end
      @(posedge CLK_I); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string nm);
      int k = 0;
      while (done_cnt == d0 && k < 300) begin
         @(posedge CLK_I); #1;
         k++;
      end
      n_chk++;
      if (done_cnt == d0) begin
         n_fail++;
         $display("FAIL %s_done_timeout: done pulses=%0d required %0d", nm, done_cnt - d0, 1);
      end
   endtask

   task automatic test_reset();
      RST_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      @(negedge CLK_I);
      n_chk++;
      if ({req_ready, CYC_O, STB_O, read_valid, write_ready, done, WE_O} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 0000000",
                  {req_ready, CYC_O, STB_O, read_valid, write_ready, done, WE_O});
      end
      n_chk++;
      if (BTE_O !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_bte: got %b required 00", BTE_O);
      end
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(negedge CLK_I);
      n_chk++;
      if (req_ready !== 1'b1 || CYC_O !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: req_ready=%b CYC_O=%b required 1 0", req_ready, CYC_O);
      end
      @(posedge CLK_I); #1;
   endtask

   task automatic test_single_write();
      int b = log_addr.size();
      int d0 = done_cnt;
      wr_start = wr_acc; wr_base = 16'h000F; wr_lim = 1;
      issue(1'b1, 32'h100, 1'b0, 14'd0);
      wait_done(d0, "single_write");
      wr_lim = 0;
      n_chk++;
      if (log_addr.size() - b != 1) begin
         n_fail++;
         $display("FAIL sw_beats: got %0d required 1", log_addr.size() - b);
      end else begin
         n_chk++;
         if (log_addr[b] !== 32'h100) begin
            n_fail++; $display("FAIL sw_addr: got %h required 00000100", log_addr[b]);
         end
         n_chk++;
         if (log_cti[b] !== 3'b000) begin
            n_fail++; $display("FAIL sw_cti: got %b required 000", log_cti[b]);
         end
         n_chk++;
         if (log_sel[b] !== 2'b11) begin
            n_fail++; $display("FAIL sw_sel: got %b required 11", log_sel[b]);
         end
         n_chk++;
         if (log_dat[b] !== 16'h000F) begin
            n_fail++; $display("FAIL sw_data: got %h required 000f", log_dat[b]);
         end
      end
      n_chk++;
      if (last_err !== 1'b0) begin
         n_fail++; $display("FAIL sw_done_err: got %b required 0", last_err);
      end
   endtask

   task automatic test_burst_write();
      logic [2:0] ec[6];
      int b = log_addr.size();
      int c = cyc_h.size();
      int d0 = done_cnt;
      int f = -1, l = -1, zeros = 0, segs = 0;
      ec = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
      wr_start = wr_acc; wr_base = 16'h0001; wr_lim = 6;
      issue(1'b1, 32'h0, 1'b1, 14'd6);
      wait_done(d0, "burst_write");
      wr_lim = 0;
      n_chk++;
      if (log_addr.size() - b != 6) begin
         n_fail++;
         $display("FAIL bw_beats: got %0d required 6", log_addr.size() - b);
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (log_addr[b+i] !== 32'(2*i) || log_dat[b+i] !== 16'(i+1)) begin
               n_fail++;
               $display("FAIL bw_beat%0d: addr %h data %h required %h %h",
                        i, log_addr[b+i], log_dat[b+i], 32'(2*i), 16'(i+1));
            end
            n_chk++;
            if (log_cti[b+i] !== ec[i]) begin
               n_fail++;
               $display("FAIL bw_cti%0d: got %b required %b", i, log_cti[b+i], ec[i]);
            end
         end
      end
      for (int i = c; i < cyc_h.size(); i++)
         if (cyc_h[i]) begin
            if (f < 0) f = i;
            l = i;
         end
      if (f >= 0) begin
         segs = 1;
         for (int i = f + 1; i <= l; i++) begin
            if (!cyc_h[i]) zeros++;
            if (cyc_h[i] && !cyc_h[i-1]) segs++;
         end
      end
      n_chk++;
      if (segs != 2 || zeros != 1) begin
         n_fail++;
         $display("FAIL bw_gap: cycles=%0d low_cycles=%0d required 2 1", segs, zeros);
      end
      n_chk++;
      if (last_err !== 1'b0) begin
         n_fail++; $display("FAIL bw_done_err: got %b required 0", last_err);
      end
   endtask

   task automatic test_burst_read_toggle();
      int r = rd_q.size();
      int b = log_addr.size();
      int v0 = stb_viol;
      int d0 = done_cnt;
      rr_tog = 1'b1;
      issue(1'b0, 32'h0, 1'b1, 14'd4);
      wait_done(d0, "burst_read");
      rr_tog = 1'b0;
      n_chk++;
      if (rd_q.size() - r != 4) begin
         n_fail++;
         $display("FAIL br_count: got %0d required 4", rd_q.size() - r);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_q[r+i] !== 16'(i+1)) begin
               n_fail++;
               $display("FAIL br_data%0d: got %h required %h", i, rd_q[r+i], 16'(i+1));
            end
         end
      end
      n_chk++;
      if (stb_viol != v0) begin
         n_fail++;
         $display("FAIL br_stb_full: strobes with full buffer=%0d required 0", stb_viol - v0);
      end
      n_chk++;
      if (log_addr.size() - b != 4 || log_cti[log_cti.size()-1] !== 3'b111) begin
         n_fail++;
         $display("FAIL br_bus: beats=%0d last_cti=%b required 4 111",
                  log_addr.size() - b, log_cti[log_cti.size()-1]);
      end
      n_chk++;
      if (last_err !== 1'b0) begin
         n_fail++; $display("FAIL br_done_err: got %b required 0", last_err);
      end
   endtask

   task automatic test_err_write();
      int b = log_addr.size();
      int c = cyc_h.size();
      int d0 = done_cnt;
      int rises = 0;
      err_addr = 32'h2; err_on = 1'b1;
      wr_start = wr_acc; wr_base = 16'h0010; wr_lim = 8;
      issue(1'b1, 32'h0, 1'b1, 14'd5);
      wait_done(d0, "err_write");
      err_on = 1'b0;
      repeat (3) @(posedge CLK_I);
      #1;
      n_chk++;
      if (wr_acc - wr_start != 5) begin
         n_fail++;
         $display("FAIL ew_accepted: got %0d required 5", wr_acc - wr_start);
      end
      wr_lim = 0;
      n_chk++;
      if (log_addr.size() - b != 2) begin
         n_fail++;
         $display("FAIL ew_bus_beats: got %0d required 2", log_addr.size() - b);
      end
      for (int i = c + 1; i < cyc_h.size(); i++)
         if (cyc_h[i] && !cyc_h[i-1]) rises++;
      n_chk++;
      if (rises != 1) begin
         n_fail++; $display("FAIL ew_cycles: got %0d required 1", rises);
      end
      n_chk++;
      if (last_err !== 1'b1) begin
         n_fail++; $display("FAIL ew_done_err: got %b required 1", last_err);
      end
   endtask

   task automatic test_err_read();
      logic [15:0] er[4];
      int r = rd_q.size();
      int b = log_addr.size();
      int d0 = done_cnt;
      er = '{16'h0001, 16'h0002, 16'h0000, 16'h0000};
      err_addr = 32'h4; err_on = 1'b1;
      issue(1'b0, 32'h0, 1'b1, 14'd4);
      wait_done(d0, "err_read");
      err_on = 1'b0;
      n_chk++;
      if (rd_q.size() - r != 4) begin
         n_fail++;
         $display("FAIL er_count: got %0d required 4", rd_q.size() - r);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_q[r+i] !== er[i]) begin
               n_fail++;
               $display("FAIL er_data%0d: got %h required %h", i, rd_q[r+i], er[i]);
            end
         end
      end
      n_chk++;
      if (log_addr.size() - b != 3) begin
         n_fail++;
         $display("FAIL er_bus_beats: got %0d required 3", log_addr.size() - b);
      end
      n_chk++;
      if (last_err !== 1'b1) begin
         n_fail++; $display("FAIL er_done_err: got %b required 1", last_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      int b = log_addr.size();
      int k = 0;
      int d0, r;
      issue(1'b0, 32'h0, 1'b1, 14'd8);
      while (log_addr.size() - b < 3 && k < 100) begin
         @(posedge CLK_I); #1;
         k++;
      end
      n_chk++;
      if (log_addr.size() - b < 3) begin
         n_fail++;
         $display("FAIL rm_progress: beats=%0d required 3", log_addr.size() - b);
      end
      RST_I = 1'b1;
      d0 = done_cnt;
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(negedge CLK_I);
      n_chk++;
      if (CYC_O !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_abort: CYC_O=%b req_ready=%b required 0 1", CYC_O, req_ready);
      end
      repeat (10) @(posedge CLK_I);
      #1;
      n_chk++;
      if (done_cnt != d0) begin
         n_fail++;
         $display("FAIL rm_no_done: pulses=%0d required 0", done_cnt - d0);
      end
      r = rd_q.size();
      d0 = done_cnt;
      issue(1'b0, 32'h10, 1'b0, 14'd0);
      wait_done(d0, "post_reset_read");
      n_chk++;
      if (rd_q.size() - r != 1 || rd_q[rd_q.size()-1] !== 16'h0009) begin
         n_fail++;
         $display("FAIL rm_read: count=%0d data=%h required 1 0009",
                  rd_q.size() - r, rd_q[rd_q.size()-1]);
      end
      n_chk++;
      if (last_err !== 1'b0) begin
         n_fail++; $display("FAIL rm_done_err: got %b required 0", last_err);
      end
   endtask

   initial begin
      RST_I = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
      req_burst = 1'b0; req_beats = '0; rr_tog = 1'b0;
      err_on = 1'b0; err_addr = '0; wr_lim = 0; wr_base = '0;
      test_reset();
      test_single_write();
      test_burst_write();
      test_burst_read_toggle();
      test_err_write();
      test_err_read();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
